// File: rtl/serial_adder_ctrl.sv
// Wide adder that reuses one N-bit slice adder over K cycles, LSB slice first,
// with a start/busy/done handshake and registered result.

module n_bit_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c_in};

endmodule

module serial_adder_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           c_in,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           c_out
);

  localparam int unsigned W  = N * K;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_sh_q;
  logic [W-1:0]    b_sh_q;
  logic [W-1:0]    acc_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;

  logic [N-1:0]    slice_sum;
  logic            slice_co;
  logic [W+N-1:0]  acc_cat;
  logic [W-1:0]    acc_nxt;

  n_bit_adder #(
    .N (N)
  ) u_slice_adder (
    .x     (a_sh_q[N-1:0]),
    .y     (b_sh_q[N-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_co)
  );

  // New slice enters at the top; the concatenation keeps K=1 free of reversed slices.
  assign acc_cat = {slice_sum, acc_q};
  assign acc_nxt = acc_cat[W+N-1:N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q  <= a_sh_q >> N;
          b_sh_q  <= b_sh_q >> N;
          acc_q   <= acc_nxt;
          carry_q <= slice_co;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            sum     <= acc_nxt;
            c_out   <= slice_co;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that adds two K*N-bit operands by time-multiplexing one n_bit_adder instance (N-bit slice) over K cycles, least-significant slice first.
- Registers the slice carry between cycles and drives a start/busy/done handshake.
- Sits between a requester issuing wide adds and the shared narrow adder datapath; the adder is instantiated inside this block.

Parameters:
- N, 4, slice width; passed to the internal n_bit_adder.
- K, 4, number of slices, K >= 1; operand width W = N*K (derived localparam).
- CW, derived localparam, slice counter width = max(1, clog2(K)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A; captured on accepted start.
- b  input  W  operand B; captured on accepted start.
- c_in  input  1  carry into slice 0; captured on accepted start.
- busy  output  1  high in RUN and DONE; registered.
- done  output  1  one-cycle pulse, high in DONE; registered.
- sum  output  W  result; registered; holds until the next DONE.
- c_out  output  1  carry out of slice K-1; registered; holds with sum.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, c_out=0; operand, carry, counter and shift registers cleared. An in-flight operation is aborted and produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 latches a→a_sh, b→b_sh, c_in→carry; cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN: each edge processes one slice.
  - Adder inputs: x=a_sh[N-1:0], y=b_sh[N-1:0], c_in=carry.
  - Updates: a_sh and b_sh shift right by N (zero-fill); acc <= {adder.sum, acc[W-1:N]}; carry <= adder.c_out; cnt++.
  - At the edge where cnt==K-1: also load sum <= {adder.sum, acc[W-1:N]} and c_out <= adder.c_out; go to DONE.
- DONE: done=1, busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - start accepted at E0 → slice i computed at E(i+1) → DONE state after E_K, so done is high in cycle K+1 → IDLE after E(K+1).
  - Throughput: one add per K+2 cycles.
- start while busy (RUN or DONE): ignored; no queuing and no effect on the in-flight operation.
- a, b, c_in may change after the accepting edge without affecting the result.
- sum and c_out change only on the DONE-entry edge or on reset; intermediate slice results are never visible on sum.
- Arithmetic: {c_out, sum} == a + b + c_in modulo 2^(W+1), unsigned. No overflow flag.
- K=1: a single RUN cycle; identical to one direct adder evaluation plus handshake.
- No combinational path from inputs to outputs.

Test Plan (N=4, K=4, W=16):
- Reset: assert rst mid-cycle with no clock edge → busy=0, done=0, sum=0x0000, c_out=0 immediately.
- Basic add: a=0x1234, b=0x4321, c_in=0, start pulsed at E0 → busy high from E0; done high only in cycle 5; sum=0x5555, c_out=0; busy low after E5.
- Full carry ripple: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1. Also check a=0x00FF, b=0x0000, c_in=1 → sum=0x0100, c_out=0.
- Start while busy: start a=0x0001, b=0x0001; at cycle 2 pulse start with a=0xAAAA, b=0x5555 → exactly one done pulse, sum=0x0002; the second request is dropped. A new start after IDLE then works.
- Reset mid-operation: start a=0x8000, b=0x8000; assert rst during RUN cycle 2 → busy=0 and sum=0 at once, no done pulse. After release, a=0x8000+0x8000 yields sum=0x0000, c_out=1.
- Back-to-back: assert start in the cycle after DONE with a=0x0F0F, b=0x00F1, c_in=1 → accepted; previous sum holds until the new DONE, then sum=0x1001, c_out=0.
